// File: rtl/if_stage_pkg.sv
// Shared widths, field positions and FSM encoding for the instruction-fetch stage.
package if_stage_pkg;

   localparam int INST_ADDR_W  = 32;
   localparam int INST_W       = 32;
   localparam int RAW_OPCODE_W = 6;
   localparam int REG_ADDR_W   = 5;
   localparam int RAW_SHAMT_W  = 5;
   localparam int RAW_FUNCT_W  = 6;
   localparam int INST_IMM_W   = 16;
   localparam int RAW_TARGET_W = 26;

   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SA_LSB     = 6;
   localparam int FN_LSB     = 0;

   // The all-zero word decodes as a NOP downstream, so bubbles are simply zero.
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      IF_FETCH = 2'd0,
      IF_HOLD  = 2'd1,
      IF_DROP  = 2'd2
   } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise contents hold.
// The stored word is split into the raw fields the decode stage consumes.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_load,
   input  logic                    i_bubble,
   input  logic [INST_W-1:0]       i_word,
   input  logic [INST_ADDR_W-1:0]  i_pc,
   output logic                    o_valid,
   output logic [INST_ADDR_W-1:0]  o_pc,
   output logic [RAW_OPCODE_W-1:0] o_opcode,
   output logic [REG_ADDR_W-1:0]   o_rs,
   output logic [REG_ADDR_W-1:0]   o_rt,
   output logic [REG_ADDR_W-1:0]   o_rd,
   output logic [RAW_SHAMT_W-1:0]  o_sa,
   output logic [RAW_FUNCT_W-1:0]  o_fn,
   output logic [INST_IMM_W-1:0]   o_imm,
   output logic [RAW_TARGET_W-1:0] o_target
);

   logic                   valid_q, valid_d;
   logic [INST_W-1:0]      word_q, word_d;
   logic [INST_ADDR_W-1:0] pc_q, pc_d;

   // Select bubble, new instruction or hold for the next register contents.
   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      pc_d    = pc_q;
      if (i_bubble) begin
         valid_d = 1'b0;
         word_d  = NOP_INST;
         pc_d    = '0;
      end else if (i_load) begin
         valid_d = 1'b1;
         word_d  = i_word;
         pc_d    = i_pc;
      end
   end

   // Register state; reset leaves a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         word_q  <= NOP_INST;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
         pc_q    <= pc_d;
      end
   end

   assign o_valid  = valid_q;
   assign o_pc     = pc_q;
   assign o_opcode = word_q[OPCODE_LSB +: RAW_OPCODE_W];
   assign o_rs     = word_q[RS_LSB +: REG_ADDR_W];
   assign o_rt     = word_q[RT_LSB +: REG_ADDR_W];
   assign o_rd     = word_q[RD_LSB +: REG_ADDR_W];
   assign o_sa     = word_q[SA_LSB +: RAW_SHAMT_W];
   assign o_fn     = word_q[FN_LSB +: RAW_FUNCT_W];
   assign o_imm    = word_q[0 +: INST_IMM_W];
   assign o_target = word_q[0 +: RAW_TARGET_W];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack fetch FSM, parks a word
// in a one-entry skid buffer when decode stalls, and discards in-flight fetches
// after a redirect. The IF/ID register itself lives in if_id_reg.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [INST_ADDR_W-1:0] PC_STEP  = 32'd4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_stall,
   input  logic                    i_flush,
   input  logic [INST_ADDR_W-1:0]  i_redirectPc,
   output logic                    o_imemReq,
   output logic [INST_ADDR_W-1:0]  o_imemAddr,
   input  logic                    i_imemAck,
   input  logic [INST_W-1:0]       i_imemData,
   output logic                    o_valid,
   output logic [INST_ADDR_W-1:0]  o_pc,
   output logic [RAW_OPCODE_W-1:0] o_opcode,
   output logic [REG_ADDR_W-1:0]   o_rs,
   output logic [REG_ADDR_W-1:0]   o_rt,
   output logic [REG_ADDR_W-1:0]   o_rd,
   output logic [RAW_SHAMT_W-1:0]  o_sa,
   output logic [RAW_FUNCT_W-1:0]  o_fn,
   output logic [INST_IMM_W-1:0]   o_imm,
   output logic [RAW_TARGET_W-1:0] o_target
);

   if_state_e              state_q, state_d;
   logic [INST_ADDR_W-1:0] pc_q, pc_d;
   logic [INST_ADDR_W-1:0] pending_pc_q, pending_pc_d;
   logic [INST_W-1:0]      skid_word_q, skid_word_d;
   logic [INST_ADDR_W-1:0] skid_pc_q, skid_pc_d;
   logic                   req_q, req_d;

   logic                   ifid_load;
   logic                   ifid_bubble;
   logic [INST_W-1:0]      ifid_word;
   logic [INST_ADDR_W-1:0] ifid_pc;
   logic                   ack_ok;

   // An ack only counts while a request is actually on the port; this is what
   // makes a stray ack right after reset harmless.
   assign ack_ok = i_imemAck & req_q;

   // Next-state, PC bookkeeping and IF/ID control; flush outranks ack and stall.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      skid_word_d  = skid_word_q;
      skid_pc_d    = skid_pc_q;
      ifid_load    = 1'b0;
      ifid_bubble  = 1'b0;
      ifid_word    = i_imemData;
      ifid_pc      = pc_q;
      case (state_q)
         IF_FETCH: begin
            if (i_flush) begin
               ifid_bubble = 1'b1;
               if (req_q && !i_imemAck) begin
                  // The memory still owes us a word for pc_q; keep asking for it
                  // and throw it away, remembering where to go afterwards.
                  pending_pc_d = i_redirectPc;
                  state_d      = IF_DROP;
               end else begin
                  pc_d = i_redirectPc;
               end
            end else if (ack_ok) begin
               pc_d = pc_q + PC_STEP;
               if (i_stall) begin
                  skid_word_d = i_imemData;
                  skid_pc_d   = pc_q;
                  state_d     = IF_HOLD;
               end else begin
                  ifid_load = 1'b1;
               end
            end else if (!i_stall) begin
               ifid_bubble = 1'b1;
            end
         end
         IF_HOLD: begin
            if (i_flush) begin
               ifid_bubble = 1'b1;
               pc_d        = i_redirectPc;
               skid_word_d = NOP_INST;
               skid_pc_d   = '0;
               state_d     = IF_FETCH;
            end else if (!i_stall) begin
               ifid_load   = 1'b1;
               ifid_word   = skid_word_q;
               ifid_pc     = skid_pc_q;
               skid_word_d = NOP_INST;
               skid_pc_d   = '0;
               state_d     = IF_FETCH;
            end
         end
         IF_DROP: begin
            ifid_bubble = 1'b1;
            if (ack_ok) begin
               // The discarded transfer completes; a redirect arriving with it wins.
               pc_d    = i_flush ? i_redirectPc : pending_pc_q;
               state_d = IF_FETCH;
            end else if (i_flush) begin
               pending_pc_d = i_redirectPc;
            end
         end
         default: begin
            ifid_bubble = 1'b1;
            state_d     = IF_FETCH;
         end
      endcase
      req_d = (state_d != IF_HOLD);
   end

   // FSM, PC, redirect target and skid buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IF_FETCH;
         pc_q         <= RESET_PC;
         pending_pc_q <= '0;
         skid_word_q  <= NOP_INST;
         skid_pc_q    <= '0;
         req_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         skid_word_q  <= skid_word_d;
         skid_pc_q    <= skid_pc_d;
         req_q        <= req_d;
      end
   end

   // In DROP the PC is not advanced, so pc_q is also the outstanding address.
   assign o_imemReq  = req_q;
   assign o_imemAddr = pc_q;

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (ifid_load),
      .i_bubble (ifid_bubble),
      .i_word   (ifid_word),
      .i_pc     (ifid_pc),
      .o_valid  (o_valid),
      .o_pc     (o_pc),
      .o_opcode (o_opcode),
      .o_rs     (o_rs),
      .o_rt     (o_rt),
      .o_rd     (o_rd),
      .o_sa     (o_sa),
      .o_fn     (o_fn),
      .o_imm    (o_imm),
      .o_target (o_target)
   );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a directed vector table, a mid-DROP reset sequence, and a
// randomized run checked against a queue-based model of the fetch stage.
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic        i_stall;
   logic        i_flush;
   logic [31:0] i_redirectPc;
   logic        o_imemReq;
   logic [31:0] o_imemAddr;
   logic        i_imemAck;
   logic [31:0] i_imemData;
   logic        o_valid;
   logic [31:0] o_pc;
   logic [5:0]  o_opcode;
   logic [4:0]  o_rs;
   logic [4:0]  o_rt;
   logic [4:0]  o_rd;
   logic [4:0]  o_sa;
   logic [5:0]  o_fn;
   logic [15:0] o_imm;
   logic [25:0] o_target;

   int n_vec;
   int n_bad;

   if_stage #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (32'd4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_stall      (i_stall),
      .i_flush      (i_flush),
      .i_redirectPc (i_redirectPc),
      .o_imemReq    (o_imemReq),
      .o_imemAddr   (o_imemAddr),
      .i_imemAck    (i_imemAck),
      .i_imemData   (i_imemData),
      .o_valid      (o_valid),
      .o_pc         (o_pc),
      .o_opcode     (o_opcode),
      .o_rs         (o_rs),
      .o_rt         (o_rt),
      .o_rd         (o_rd),
      .o_sa         (o_sa),
      .o_fn         (o_fn),
      .o_imm        (o_imm),
      .o_target     (o_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        ack;
      logic [31:0] redir;
      logic [31:0] data;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_word;
      logic        e_req;
      logic [31:0] e_addr;
   } vec_t;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] w;
   } inst_t;

   // Reference model: IF/ID contents, a queue for the parked word, the next
   // fetch address, and whether the port's current transfer is being thrown away.
   inst_t       m_ifid;
   inst_t       m_skid[$];
   logic [31:0] m_pc;
   logic [31:0] m_pending;
   logic        m_discard;
   logic        m_req;

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic e_valid, input logic [31:0] e_pc,
                            input logic [31:0] e_word, input logic e_req, input logic [31:0] e_addr);
      logic [31:0] w;
      w = e_word;
      cmp({tag, ".valid_pc"}, {31'd0, o_valid, o_pc}, {31'd0, e_valid, e_pc});
      cmp({tag, ".fields"}, {32'd0, o_opcode, o_rs, o_rt, o_rd, o_sa, o_fn}, {32'd0, w});
      cmp({tag, ".imm_target"}, {22'd0, o_imm, o_target}, {22'd0, w[15:0], w[25:0]});
      cmp({tag, ".req"}, {63'd0, o_imemReq}, {63'd0, e_req});
      if (e_req)
         cmp({tag, ".addr"}, {32'd0, o_imemAddr}, {32'd0, e_addr});
   endtask

   task automatic drive(input logic s, input logic f, input logic [31:0] r,
                        input logic a, input logic [31:0] d);
      i_stall      = s;
      i_flush      = f;
      i_redirectPc = r;
      i_imemAck    = a;
      i_imemData   = d;
   endtask

   task automatic model_reset();
      m_ifid    = '0;
      m_skid.delete();
      m_pc      = 32'h0;
      m_pending = 32'h0;
      m_discard = 1'b0;
      m_req     = 1'b0;
   endtask

   // One clock edge of the model, using the inputs that were applied before it.
   task automatic model_step();
      logic  ack_ok;
      inst_t nxt;
      ack_ok = i_imemAck && m_req;
      if (i_flush) begin
         m_ifid = '0;
         m_skid.delete();
         if (m_req && !i_imemAck) begin
            m_pending = i_redirectPc;
            m_discard = 1'b1;
         end else begin
            m_pc      = i_redirectPc;
            m_discard = 1'b0;
         end
      end else if (m_discard) begin
         m_ifid = '0;
         if (ack_ok) begin
            m_pc      = m_pending;
            m_discard = 1'b0;
         end
      end else if (m_skid.size() > 0) begin
         if (!i_stall) m_ifid = m_skid.pop_front();
      end else if (ack_ok) begin
         nxt = '{v: 1'b1, pc: m_pc, w: i_imemData};
         if (i_stall) m_skid.push_back(nxt);
         else         m_ifid = nxt;
         m_pc = m_pc + 32'd4;
      end else if (!i_stall) begin
         m_ifid = '0;
      end
      m_req = (m_skid.size() == 0);
   endtask

   localparam logic [31:0] W1   = 32'h3421_0005;
   localparam logic [31:0] W2   = 32'h8C22_0010;
   localparam logic [31:0] W3   = 32'h0C00_0040;
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   vec_t tbl[22];

   initial begin
      logic        s, f, a;
      logic [31:0] r, d;
      logic        prev_v;
      logic [31:0] prev_pc;

      n_vec = 0;
      n_bad = 0;

      //           stall flush ack  redir         data   e_valid e_pc          e_word e_req e_addr
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0,        32'h0, 1'b1, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,        W1,    1'b0, 32'h0,        32'h0, 1'b1, 32'h0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b1, 32'h0,        W1,    1'b1, 32'h4};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,        W1,    1'b0, 32'h0,        32'h0, 1'b1, 32'h4};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0, 1'b1, 32'h4,        W1,    1'b1, 32'h8};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h0,        W2,    1'b1, 32'h4,        W1,    1'b1, 32'h8};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0, 1'b1, 32'h4,        W1,    1'b0, 32'h0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b1, 32'h4,        W1,    1'b0, 32'h0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h100,      32'h0, 1'b1, 32'h8,        W2,    1'b1, 32'hC};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0,        32'h0, 1'b1, 32'hC};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h0,        JUNK,  1'b0, 32'h0,        32'h0, 1'b1, 32'hC};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0,        32'h0, 1'b1, 32'h100};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h200,      JUNK,  1'b0, 32'h0,        32'h0, 1'b1, 32'h100};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0,        32'h0, 1'b1, 32'h200};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0,       32'h0, 1'b1, 32'h200};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h0,        JUNK,  1'b0, 32'h0,        32'h0, 1'b1, 32'h200};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0,        32'h0, 1'b1, 32'hFFFF_FFFC};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 32'h0,        W3,    1'b0, 32'h0,        32'h0, 1'b1, 32'hFFFF_FFFC};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b1, 32'hFFFF_FFFC, W3,   1'b1, 32'h0};
      tbl[20] = '{1'b0, 1'b1, 1'b0, 32'h40,       32'h0, 1'b0, 32'h0,        32'h0, 1'b1, 32'h0};
      tbl[21] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0,        32'h0, 1'b1, 32'h0};

      // Reset state.
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table; the last entry leaves the stage in DROP with req up.
      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].ack, tbl[i].data);
         #1;
         check_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_word,
                   tbl[i].e_req, tbl[i].e_addr);
         $display("vec %0d: stall=%0b flush=%0b ack=%0b -> valid=%0b pc=%h req=%0b addr=%h",
                  i, tbl[i].stall, tbl[i].flush, tbl[i].ack, o_valid, o_pc, o_imemReq, o_imemAddr);
         if (i < 21) begin
            @(posedge clk);
            @(negedge clk);
         end
      end

      // Asynchronous reset in the middle of a DROP cycle clears outputs at once.
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      $display("async reset mid-DROP: valid=%0b req=%0b pc=%h", o_valid, o_imemReq, o_pc);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b1, JUNK);   // stray ack while req is low
      #1;
      check_out("post_rst0", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      check_out("post_rst1", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check_out("post_rst2", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      $display("post reset: stray ack ignored, req=%0b addr=%h valid=%0b", o_imemReq, o_imemAddr, o_valid);

      // Randomized run against the model.
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      prev_v  = 1'b0;
      prev_pc = 32'h0;
      for (int c = 0; c < 1500; c++) begin
         check_out($sformatf("rnd%0d", c), m_ifid.v, m_ifid.pc, m_ifid.w, m_req, m_pc);
         if (m_ifid.v && (!prev_v || m_ifid.pc != prev_pc))
            $display("rnd %0d: IF/ID pc=%h word=%h", c, o_pc, {o_opcode, o_rs, o_rt, o_rd, o_sa, o_fn});
         prev_v  = m_ifid.v;
         prev_pc = m_ifid.pc;
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 15) == 0);
         r = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         a = ($urandom_range(0, 2) == 0);
         d = $urandom();
         drive(s, f, r, a, d);
         @(posedge clk);
         model_step();
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
